// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register: captures register-file reads and decoded control into EX,
// with flush, external stall and load-use bubble insertion plus a saturating bubble counter.
module id_ex_pipe_reg #(
  parameter int DATA_W   = 16,
  parameter int REG_ID_W = 4,
  parameter int ALU_OP_W = 4,
  parameter int CNT_W    = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                stall_i,
  input  logic                flush_i,
  input  logic                id_valid_i,
  input  logic [REG_ID_W-1:0] id_src_reg1_i,
  input  logic [REG_ID_W-1:0] id_src_reg2_i,
  input  logic                id_uses_src1_i,
  input  logic                id_uses_src2_i,
  input  logic [REG_ID_W-1:0] id_dst_reg_i,
  input  logic                id_write_reg_i,
  input  logic                id_mem_read_i,
  input  logic                id_mem_write_i,
  input  logic [ALU_OP_W-1:0] id_alu_op_i,
  input  logic [DATA_W-1:0]   id_src_data1_i,
  input  logic [DATA_W-1:0]   id_src_data2_i,
  input  logic [DATA_W-1:0]   id_imm_i,
  input  logic [DATA_W-1:0]   id_pc_plus2_i,
  output logic [REG_ID_W-1:0] ex_src_reg1_o,
  output logic [REG_ID_W-1:0] ex_src_reg2_o,
  output logic                ex_uses_src1_o,
  output logic                ex_uses_src2_o,
  output logic [REG_ID_W-1:0] ex_dst_reg_o,
  output logic                ex_write_reg_o,
  output logic                ex_mem_read_o,
  output logic                ex_mem_write_o,
  output logic [ALU_OP_W-1:0] ex_alu_op_o,
  output logic [DATA_W-1:0]   ex_src_data1_o,
  output logic [DATA_W-1:0]   ex_src_data2_o,
  output logic [DATA_W-1:0]   ex_imm_o,
  output logic [DATA_W-1:0]   ex_pc_plus2_o,
  output logic                ex_valid_o,
  output logic                load_use_stall_o,
  output logic [CNT_W-1:0]    bubble_count_o
);

  typedef struct packed {
    logic [REG_ID_W-1:0] src_reg1;
    logic [REG_ID_W-1:0] src_reg2;
    logic                uses_src1;
    logic                uses_src2;
    logic [REG_ID_W-1:0] dst_reg;
    logic                write_reg;
    logic                mem_read;
    logic                mem_write;
    logic [ALU_OP_W-1:0] alu_op;
    logic [DATA_W-1:0]   src_data1;
    logic [DATA_W-1:0]   src_data2;
    logic [DATA_W-1:0]   imm;
    logic [DATA_W-1:0]   pc_plus2;
  } stage_t;

  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  stage_t            idStage;
  stage_t            exStage_q, exStage_d;
  logic              exValid_q, exValid_d;
  logic [CNT_W-1:0]  bubbleCnt_q, bubbleCnt_d;
  logic              srcHit;
  logic              hazard;

  assign idStage = '{
    src_reg1:  id_src_reg1_i,
    src_reg2:  id_src_reg2_i,
    uses_src1: id_uses_src1_i,
    uses_src2: id_uses_src2_i,
    dst_reg:   id_dst_reg_i,
    write_reg: id_write_reg_i,
    mem_read:  id_mem_read_i,
    mem_write: id_mem_write_i,
    alu_op:    id_alu_op_i,
    src_data1: id_src_data1_i,
    src_data2: id_src_data2_i,
    imm:       id_imm_i,
    pc_plus2:  id_pc_plus2_i
  };

  // A load in EX whose destination is read by the valid ID instruction; R0 gets no exemption.
  always_comb begin
    srcHit = (id_uses_src1_i && (id_src_reg1_i == exStage_q.dst_reg)) ||
             (id_uses_src2_i && (id_src_reg2_i == exStage_q.dst_reg));
    hazard = exValid_q && exStage_q.mem_read && exStage_q.write_reg &&
             id_valid_i && srcHit;
  end

  assign load_use_stall_o = hazard && !flush_i;

  always_comb begin
    exStage_d   = exStage_q;
    exValid_d   = exValid_q;
    bubbleCnt_d = bubbleCnt_q;
    if (flush_i) begin
      exStage_d = '0;
      exValid_d = 1'b0;
    end else if (stall_i) begin
      exStage_d = exStage_q;
      exValid_d = exValid_q;
    end else if (hazard) begin
      exStage_d = '0;
      exValid_d = 1'b0;
      if (bubbleCnt_q != CntMax) begin
        bubbleCnt_d = bubbleCnt_q + CNT_W'(1);
      end
    end else begin
      exStage_d = idStage;
      exValid_d = id_valid_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      exStage_q   <= '0;
      exValid_q   <= 1'b0;
      bubbleCnt_q <= '0;
    end else begin
      exStage_q   <= exStage_d;
      exValid_q   <= exValid_d;
      bubbleCnt_q <= bubbleCnt_d;
    end
  end

  assign ex_src_reg1_o  = exStage_q.src_reg1;
  assign ex_src_reg2_o  = exStage_q.src_reg2;
  assign ex_uses_src1_o = exStage_q.uses_src1;
  assign ex_uses_src2_o = exStage_q.uses_src2;
  assign ex_dst_reg_o   = exStage_q.dst_reg;
  assign ex_write_reg_o = exStage_q.write_reg;
  assign ex_mem_read_o  = exStage_q.mem_read;
  assign ex_mem_write_o = exStage_q.mem_write;
  assign ex_alu_op_o    = exStage_q.alu_op;
  assign ex_src_data1_o = exStage_q.src_data1;
  assign ex_src_data2_o = exStage_q.src_data2;
  assign ex_imm_o       = exStage_q.imm;
  assign ex_pc_plus2_o  = exStage_q.pc_plus2;
  assign ex_valid_o     = exValid_q;
  assign bubble_count_o = bubbleCnt_q;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Self-checking bench for id_ex_pipe_reg: directed scenarios plus random traffic against
// a per-instruction reference model; a 3-bit-counter instance exercises saturation.
module tb_id_ex_pipe_reg;

  typedef struct packed {
    logic [3:0]  src_reg1;
    logic [3:0]  src_reg2;
    logic        uses_src1;
    logic        uses_src2;
    logic [3:0]  dst_reg;
    logic        write_reg;
    logic        mem_read;
    logic        mem_write;
    logic [3:0]  alu_op;
    logic [15:0] src_data1;
    logic [15:0] src_data2;
    logic [15:0] imm;
    logic [15:0] pc_plus2;
  } inst_t;

  logic  clk = 1'b0;
  logic  rst, stall, flush, idValid;
  inst_t idIn;

  inst_t       obsEx, obsSmEx;
  logic        exValid, smValid, lus, smLus;
  logic [15:0] bubbleCount;
  logic [2:0]  smCount;

  logic [3:0]  o_sr1, o_sr2, o_dst, o_alu, s_sr1, s_sr2, s_dst, s_alu;
  logic        o_u1, o_u2, o_wr, o_mr, o_mw, s_u1, s_u2, s_wr, s_mr, s_mw;
  logic [15:0] o_d1, o_d2, o_imm, o_pc, s_d1, s_d2, s_imm, s_pc;

  inst_t mEx;
  bit    mValid;
  int    mCnt, mSmCnt;
  bit    modelKnown = 1'b0;
  int    assertCount = 0;
  int    failCount = 0;

  always #5 clk = ~clk;

  id_ex_pipe_reg dut (
    .clk_i(clk), .rst_i(rst), .stall_i(stall), .flush_i(flush), .id_valid_i(idValid),
    .id_src_reg1_i(idIn.src_reg1), .id_src_reg2_i(idIn.src_reg2),
    .id_uses_src1_i(idIn.uses_src1), .id_uses_src2_i(idIn.uses_src2),
    .id_dst_reg_i(idIn.dst_reg), .id_write_reg_i(idIn.write_reg),
    .id_mem_read_i(idIn.mem_read), .id_mem_write_i(idIn.mem_write),
    .id_alu_op_i(idIn.alu_op), .id_src_data1_i(idIn.src_data1),
    .id_src_data2_i(idIn.src_data2), .id_imm_i(idIn.imm), .id_pc_plus2_i(idIn.pc_plus2),
    .ex_src_reg1_o(o_sr1), .ex_src_reg2_o(o_sr2), .ex_uses_src1_o(o_u1),
    .ex_uses_src2_o(o_u2), .ex_dst_reg_o(o_dst), .ex_write_reg_o(o_wr),
    .ex_mem_read_o(o_mr), .ex_mem_write_o(o_mw), .ex_alu_op_o(o_alu),
    .ex_src_data1_o(o_d1), .ex_src_data2_o(o_d2), .ex_imm_o(o_imm), .ex_pc_plus2_o(o_pc),
    .ex_valid_o(exValid), .load_use_stall_o(lus), .bubble_count_o(bubbleCount)
  );

  // Same stimulus, narrow counter so saturation is reachable in a few hazards.
  id_ex_pipe_reg #(.CNT_W(3)) dutSmall (
    .clk_i(clk), .rst_i(rst), .stall_i(stall), .flush_i(flush), .id_valid_i(idValid),
    .id_src_reg1_i(idIn.src_reg1), .id_src_reg2_i(idIn.src_reg2),
    .id_uses_src1_i(idIn.uses_src1), .id_uses_src2_i(idIn.uses_src2),
    .id_dst_reg_i(idIn.dst_reg), .id_write_reg_i(idIn.write_reg),
    .id_mem_read_i(idIn.mem_read), .id_mem_write_i(idIn.mem_write),
    .id_alu_op_i(idIn.alu_op), .id_src_data1_i(idIn.src_data1),
    .id_src_data2_i(idIn.src_data2), .id_imm_i(idIn.imm), .id_pc_plus2_i(idIn.pc_plus2),
    .ex_src_reg1_o(s_sr1), .ex_src_reg2_o(s_sr2), .ex_uses_src1_o(s_u1),
    .ex_uses_src2_o(s_u2), .ex_dst_reg_o(s_dst), .ex_write_reg_o(s_wr),
    .ex_mem_read_o(s_mr), .ex_mem_write_o(s_mw), .ex_alu_op_o(s_alu),
    .ex_src_data1_o(s_d1), .ex_src_data2_o(s_d2), .ex_imm_o(s_imm), .ex_pc_plus2_o(s_pc),
    .ex_valid_o(smValid), .load_use_stall_o(smLus), .bubble_count_o(smCount)
  );

  assign obsEx   = {o_sr1, o_sr2, o_u1, o_u2, o_dst, o_wr, o_mr, o_mw, o_alu,
                    o_d1, o_d2, o_imm, o_pc};
  assign obsSmEx = {s_sr1, s_sr2, s_u1, s_u2, s_dst, s_wr, s_mr, s_mw, s_alu,
                    s_d1, s_d2, s_imm, s_pc};

  function automatic inst_t randInst(input int regMax);
    inst_t r;
    r.src_reg1  = 4'($urandom_range(0, regMax));
    r.src_reg2  = 4'($urandom_range(0, regMax));
    r.uses_src1 = 1'($urandom);
    r.uses_src2 = 1'($urandom);
    r.dst_reg   = 4'($urandom_range(0, regMax));
    r.write_reg = 1'($urandom);
    r.mem_read  = 1'($urandom);
    r.mem_write = 1'($urandom);
    r.alu_op    = 4'($urandom);
    r.src_data1 = 16'($urandom);
    r.src_data2 = 16'($urandom);
    r.imm       = 16'($urandom);
    r.pc_plus2  = 16'($urandom);
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // One clock: check the combinational stall, advance the model, then check registered state.
  task automatic applyStimulus(input string tag);
    bit hz;
    #1;
    hz = mValid && mEx.mem_read && mEx.write_reg && idValid &&
         ((idIn.uses_src1 && idIn.src_reg1 == mEx.dst_reg) ||
          (idIn.uses_src2 && idIn.src_reg2 == mEx.dst_reg));
    if (modelKnown) begin
      checkOutput({tag, ".lus"}, 128'(lus), 128'(hz && !flush));
      checkOutput({tag, ".smLus"}, 128'(smLus), 128'(hz && !flush));
    end
    @(posedge clk);
    if (!rst) begin
      mEx = '0; mValid = 1'b0; mCnt = 0; mSmCnt = 0; modelKnown = 1'b1;
    end else if (flush) begin
      mEx = '0; mValid = 1'b0;
    end else if (stall) begin
      mValid = mValid;
    end else if (hz) begin
      mEx = '0; mValid = 1'b0;
      if (mCnt < 65535) mCnt++;
      if (mSmCnt < 7) mSmCnt++;
    end else begin
      mEx = idIn; mValid = idValid;
    end
    #1;
    if (modelKnown) begin
      checkOutput({tag, ".ex"}, 128'(obsEx), 128'(mEx));
      checkOutput({tag, ".exValid"}, 128'(exValid), 128'(mValid));
      checkOutput({tag, ".count"}, 128'(bubbleCount), 128'(mCnt));
      checkOutput({tag, ".smEx"}, 128'(obsSmEx), 128'(mEx));
      checkOutput({tag, ".smValid"}, 128'(smValid), 128'(mValid));
      checkOutput({tag, ".smCount"}, 128'(smCount), 128'(mSmCnt));
    end
  endtask

  task automatic loadEx(input logic [3:0] dst, input logic isLoad);
    idIn = randInst(15);
    idIn.dst_reg = dst; idIn.mem_read = isLoad; idIn.write_reg = 1'b1;
    idValid = 1'b1; flush = 1'b0; stall = 1'b0;
    applyStimulus("loadEx");
  endtask

  task automatic setConsumer(input logic [3:0] reg2, input logic use2);
    idIn = randInst(15);
    idIn.uses_src1 = 1'b0; idIn.uses_src2 = use2; idIn.src_reg2 = reg2;
    idValid = 1'b1;
  endtask

  initial begin
    rst = 1'b0; stall = 1'b0; flush = 1'b0; idValid = 1'b1; idIn = randInst(15);
    mEx = '0; mValid = 1'b0; mCnt = 0; mSmCnt = 0;

    applyStimulus("reset1");
    idIn = randInst(15); idValid = 1'b1; stall = 1'b1;
    applyStimulus("reset2");
    checkOutput("resetCount", 128'(bubbleCount), 128'(0));
    rst = 1'b1; stall = 1'b0;

    idIn = randInst(15); idIn.src_data1 = 16'hBEEF; idIn.dst_reg = 4'd5; idValid = 1'b1;
    applyStimulus("passThru");
    checkOutput("passThruData", 128'(o_d1), 128'(16'hBEEF));
    checkOutput("passThruDst", 128'(o_dst), 128'(4'd5));
    checkOutput("passThruValid", 128'(exValid), 128'(1'b1));

    loadEx(4'd3, 1'b1);
    setConsumer(4'd3, 1'b1);
    #1 checkOutput("loadUseStall", 128'(lus), 128'(1'b1));
    applyStimulus("loadUse");
    checkOutput("loadUseBubble", 128'(exValid), 128'(1'b0));
    checkOutput("loadUseCount", 128'(bubbleCount), 128'(1));
    applyStimulus("loadUseRetry");
    checkOutput("loadUseLoaded", 128'(exValid), 128'(1'b1));

    loadEx(4'd3, 1'b1);
    setConsumer(4'd3, 1'b0);
    applyStimulus("noUseSrc2");
    loadEx(4'd3, 1'b0);
    setConsumer(4'd3, 1'b1);
    applyStimulus("notLoad");

    loadEx(4'd7, 1'b0);
    flush = 1'b1; stall = 1'b1; idIn = randInst(15);
    applyStimulus("flushStall");
    checkOutput("flushStallValid", 128'(exValid), 128'(1'b0));
    loadEx(4'd0, 1'b1);
    setConsumer(4'd0, 1'b1); flush = 1'b1;
    applyStimulus("hazardFlush");
    checkOutput("hazardFlushCount", 128'(bubbleCount), 128'(1));
    flush = 1'b0;

    loadEx(4'd9, 1'b0);
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      idIn = randInst(15); idValid = 1'(i);
      applyStimulus("stallHold");
    end
    stall = 1'b0;

    for (int i = 0; i < 9; i++) begin
      loadEx(4'(i), 1'b1);
      setConsumer(4'(i), 1'b1);
      applyStimulus("satHazard");
    end
    checkOutput("smSaturated", 128'(smCount), 128'(3'd7));
    checkOutput("bigCount", 128'(bubbleCount), 128'(10));

    loadEx(4'd2, 1'b1);
    setConsumer(4'd2, 1'b1); rst = 1'b0;
    applyStimulus("resetMidHazard");
    rst = 1'b1;

    for (int i = 0; i < 400; i++) begin
      idIn    = randInst(3);
      idValid = ($urandom_range(0, 9) != 0);
      flush   = ($urandom_range(0, 11) == 0);
      stall   = ($urandom_range(0, 7) == 0);
      rst     = ($urandom_range(0, 99) != 0);
      applyStimulus("random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
